uart_tx_arb: RTL and testbench

Round-robin arbiter and sequencer that shares a single `uart_tx` transmitter between up to four byte requesters, for example the RX-echo path, a status reporter and a command-reply path. It sits between the requesters and `uart_tx`. It accepts one byte at a time over a valid/ready handshake and issues the single-cycle `send_en` pulse. It then tracks `tx_busy`/`tx_done` until the frame completes, with a watchdog for a transmitter that never starts.

---
 rtl/uart_tx_arb.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_arb.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that shares one uart_tx between up to four
// byte requesters. It accepts one byte at a time over valid/ready and fires a
// single send_en pulse. It then follows tx_busy/tx_done until the frame ends,
// with a start watchdog for a transmitter that never responds.
module uart_tx_arb #(
  parameter int N             = 2,
  parameter int START_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [8*N-1:0]   req_data,
  output logic [N-1:0]     req_ready,
  output logic [7:0]       tx_data,
  output logic             send_en,
  input  logic             tx_busy,
  input  logic             tx_done,
  output logic [1:0]       grant_id,
  output logic             frame_done,
  output logic             timeout_err
);

  // Watchdog counter must be able to hold START_TIMEOUT itself.
  localparam int               CNT_W     = $clog2(START_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(START_TIMEOUT);
  // Reset "last winner" to the top index so requester 0 is scanned first.
  localparam logic [1:0]       LAST_RST  = 2'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_START     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       grant_id_q, grant_id_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_done_q, frame_done_d;

  // Requests padded to the four-slot maximum so indexing is width-uniform.
  logic [3:0]  valid_pad;
  logic [31:0] data_pad;
  logic        win_found;
  logic [1:0]  win_idx;
  logic [7:0]  win_data;
  logic        grant_en;
  logic        send_en_c;
  logic        timeout_err_c;

  assign valid_pad = 4'(req_valid);
  assign data_pad  = 32'(req_data);

  // Index base+offset wrapped into 0..N-1; base < N and offset <= N, so one
  // conditional subtraction is enough.
  function automatic logic [1:0] rr_index(input logic [1:0] base, input int offset);
    int sum;
    sum = int'(base) + offset;
    if (sum >= N) sum = sum - N;
    return 2'(sum);
  endfunction

  // Round-robin winner: first valid requester scanning last+1, last+2, ...
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so no
    // path leaves it unassigned and no latch is inferred.
    win_found = 1'b0;
    win_idx   = last_q;
    // Walk from the farthest candidate to the nearest; the nearest valid one
    // is written last and therefore wins.
    for (int k = N; k >= 1; k--) begin
      if (valid_pad[rr_index(last_q, k)]) begin
        win_found = 1'b1;
        win_idx   = rr_index(last_q, k);
      end
    end
    win_data = data_pad[{win_idx, 3'b000} +: 8];
  end

  // A grant happens only in IDLE with the transmitter quiet. Gating with rst
  // keeps req_ready low while reset is held, even though IDLE is the reset state.
  assign grant_en = (state_q == S_IDLE) && !tx_busy && win_found && !rst;

  // One-hot acceptance pulse toward the winning requester.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      req_ready[i] = grant_en && (win_idx == 2'(i));
    end
  end

  // Next-state, datapath and pulse-output logic of the sequencer.
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    grant_id_d    = grant_id_q;
    tx_data_d     = tx_data_q;
    cnt_d         = cnt_q;
    frame_done_d  = 1'b0;
    send_en_c     = 1'b0;
    timeout_err_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_en) begin
          last_d     = win_idx;
          grant_id_d = win_idx;
          tx_data_d  = win_data;
          state_d    = S_START;
        end
      end

      S_START: begin
        send_en_c = 1'b1;
        cnt_d     = '0;
        state_d   = S_WAIT_BUSY;
      end

      S_WAIT_BUSY: begin
        // Saturating count of cycles spent waiting for the transmitter.
        if (cnt_q != CNT_LIMIT) cnt_d = cnt_q + 1'b1;
        // tx_done outranks both busy and the watchdog, so a transmitter that
        // finishes exactly at the limit still reports a completed frame.
        if (tx_done) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end else if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_LIMIT) begin
          // Byte is dropped; the next grant may follow straight away.
          timeout_err_c = 1'b1;
          state_d       = S_IDLE;
        end
      end

      S_WAIT_DONE: begin
        // We only stay here while busy is high, so busy low now means it fell;
        // a fall without tx_done is still taken as the end of the frame.
        if (tx_done || !tx_busy) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_q       <= LAST_RST;
      grant_id_q   <= '0;
      tx_data_q    <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      last_q       <= last_d;
      grant_id_q   <= grant_id_d;
      tx_data_q    <= tx_data_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign frame_done  = frame_done_q;
  assign send_en     = send_en_c;
  assign timeout_err = timeout_err_c;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Testbench for uart_tx_arb (N=3, START_TIMEOUT=16). A behavioural uart_tx
// stub (4 clocks per bit) drives tx_busy/tx_done and a serial line. A serial
// receiver decodes that line. Expected grants go into a scoreboard that a
// monitor pops on every send_en.
module tb_uart_tx_arb;

  localparam int N             = 3;
  localparam int START_TIMEOUT = 16;
  localparam int BAUD          = 4;

  typedef enum int {M_NORMAL, M_IGNORE, M_LATE_DONE} stub_mode_e;
  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           send_en;
  logic           tx_busy;
  logic           tx_done;
  logic [1:0]     grant_id;
  logic           frame_done;
  logic           timeout_err;

  logic       stub_busy;
  logic       stub_done;
  logic       ext_busy;
  logic       ser;
  stub_mode_e stub_mode;

  int total    = 0;
  int bad      = 0;
  int send_cnt = 0;
  int fd_cnt   = 0;
  int to_cnt   = 0;
  int rx_cnt   = 0;

  exp_t       sb_q[$];
  logic [7:0] ser_q[$];

  assign tx_busy = stub_busy | ext_busy;
  assign tx_done = stub_done;

  always #5 clk = ~clk;

  uart_tx_arb #(
    .N             (N),
    .START_TIMEOUT (START_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .send_en     (send_en),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .grant_id    (grant_id),
    .frame_done  (frame_done),
    .timeout_err (timeout_err)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic expect_frame(input logic [1:0] id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"},   32'(req_ready),   0);
    check({tag, " tx_data"},     32'(tx_data),     0);
    check({tag, " send_en"},     32'(send_en),     0);
    check({tag, " grant_id"},    32'(grant_id),    0);
    check({tag, " frame_done"},  32'(frame_done),  0);
    check({tag, " timeout_err"}, 32'(timeout_err), 0);
  endtask

  // Advances to the next falling edge, then waits (bounded) for any req_ready.
  task automatic wait_ready(input string name, input int exp_ready);
    int c = 0;
    @(negedge clk);
    while (req_ready == '0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    check(name, 32'(req_ready), exp_ready);
  endtask

  task automatic wait_fd(input string name, input int target);
    int c = 0;
    while (fd_cnt < target && c < 400) begin
      @(negedge clk);
      c++;
    end
    check(name, fd_cnt, target);
  endtask

  task automatic wait_tx_done(input string name);
    int c = 0;
    while (tx_done !== 1'b1 && c < 300) begin
      @(negedge clk);
      c++;
    end
    check(name, 32'(tx_done), 1);
  endtask

  // uart_tx stub: start bit, 8 data bits LSB first, stop bit, then a tx_done
  // pulse with busy low. Other modes ignore send_en or pulse tx_done late.
  initial begin : stub
    logic [9:0] bits;
    stub_busy = 1'b0;
    stub_done = 1'b0;
    ser       = 1'b1;
    forever begin
      @(negedge clk);
      if (send_en && stub_mode == M_NORMAL) begin
        bits = {1'b1, tx_data, 1'b0};
        @(posedge clk);
        #1;
        stub_busy = 1'b1;
        for (int b = 0; b < 10; b++) begin
          ser = bits[b];
          repeat (BAUD) @(posedge clk);
          #1;
        end
        ser       = 1'b1;
        stub_busy = 1'b0;
        stub_done = 1'b1;
        @(posedge clk);
        #1;
        stub_done = 1'b0;
      end else if (send_en && stub_mode == M_LATE_DONE) begin
        // tx_done lands START_TIMEOUT cycles after WAIT_BUSY entry.
        repeat (START_TIMEOUT + 1) @(posedge clk);
        #1;
        stub_done = 1'b1;
        @(posedge clk);
        #1;
        stub_done = 1'b0;
      end
    end
  end

  // Monitor: every send_en pops the scoreboard and checks id/byte.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (send_en) begin
        send_cnt++;
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL send_en: unexpected pulse, grant_id=%0d tx_data=0x%0h", grant_id, tx_data);
        end else begin
          e = sb_q.pop_front();
          check("send grant_id", 32'(grant_id), 32'(e.id));
          check("send tx_data",  32'(tx_data),  32'(e.data));
          if (stub_mode == M_NORMAL) ser_q.push_back(e.data);
        end
      end
      if (frame_done)  fd_cnt++;
      if (timeout_err) to_cnt++;
    end
  end

  // Serial receiver: samples each bit mid-cell and checks the byte.
  initial begin : receiver
    logic [7:0] rx;
    logic [7:0] want;
    forever begin
      @(negedge clk);
      if (ser === 1'b0) begin
        repeat (BAUD + BAUD / 2) @(negedge clk);
        for (int j = 0; j < 8; j++) begin
          rx[j] = ser;
          if (j < 7) repeat (BAUD) @(negedge clk);
        end
        repeat (BAUD) @(negedge clk);
        rx_cnt++;
        if (ser_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL serial: got byte 0x%0h with nothing expected", rx);
        end else begin
          want = ser_q.pop_front();
          check("serial byte", 32'(rx), 32'(want));
        end
      end
    end
  end

  initial begin : global_limit
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1);
  end

  initial begin : main
    int lock_hits;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    ext_busy  = 1'b0;
    stub_mode = M_NORMAL;

    // Reset state, with all requesters valid to show req_ready stays low.
    repeat (2) @(posedge clk);
    #1;
    req_valid = 3'b111;
    req_data  = {8'h33, 8'h22, 8'h11};
    @(negedge clk);
    check_reset_outputs("reset");

    // Single requester: ready at T0, send_en at T0+1, frame_done after tx_done.
    @(posedge clk);
    #1;
    req_valid = 3'b001;
    req_data  = {8'h00, 8'h00, 8'h69};
    expect_frame(2'd0, 8'h69);
    rst = 1'b0;
    @(negedge clk);
    check("single req_ready T0", 32'(req_ready), 1);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    check("single send_en T0+1", 32'(send_en), 1);
    check("single tx_data T0+1", 32'(tx_data), 'h69);
    @(negedge clk);
    check("single send_en T0+2", 32'(send_en), 0);
    wait_tx_done("single");
    check("single frame_done at tx_done", 32'(frame_done), 0);
    @(negedge clk);
    check("single frame_done +1", 32'(frame_done), 1);
    @(negedge clk);
    check("single frame_done +2", 32'(frame_done), 0);
    wait_fd("single fd count", 1);

    // Round-robin: fresh reset so requester 0 leads; order 0,1,2,0,1,2.
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    req_data  = {8'hA2, 8'hA1, 8'hA0};
    req_valid = 3'b111;
    rst       = 1'b0;
    for (int r = 0; r < 2; r++) begin
      expect_frame(2'd0, 8'hA0);
      expect_frame(2'd1, 8'hA1);
      expect_frame(2'd2, 8'hA2);
    end
    @(negedge clk);
    check("rr grant 1", 32'(req_ready), 1);
    wait_ready("rr grant 2", 2);
    wait_ready("rr grant 3", 4);
    wait_ready("rr grant 4", 1);
    wait_ready("rr grant 5", 2);
    wait_ready("rr grant 6", 4);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_fd("rr fd count", 7);

    // Busy lockout: external busy for 50 cycles blocks the grant.
    @(posedge clk);
    #1;
    ext_busy  = 1'b1;
    req_valid = 3'b010;
    req_data  = {8'h00, 8'hB1, 8'h00};
    expect_frame(2'd1, 8'hB1);
    lock_hits = 0;
    repeat (50) begin
      @(negedge clk);
      if (req_ready != '0 || send_en) lock_hits++;
    end
    check("lockout no grant", lock_hits, 0);
    @(posedge clk);
    #1;
    ext_busy = 1'b0;
    @(negedge clk);
    check("lockout release grant", 32'(req_ready), 2);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_fd("lockout fd count", 8);

    // Watchdog: stub ignores send_en; timeout at WAIT_BUSY entry + 16.
    @(posedge clk);
    #1;
    stub_mode = M_IGNORE;
    req_valid = 3'b101;
    req_data  = {8'hC2, 8'h00, 8'hC0};
    expect_frame(2'd2, 8'hC2);
    expect_frame(2'd0, 8'hC0);
    wait_ready("wd first grant", 4);
    @(posedge clk);
    #1;
    req_valid = 3'b001;
    @(negedge clk);
    check("wd send_en", 32'(send_en), 1);
    repeat (START_TIMEOUT) @(negedge clk);
    check("wd timeout_err early", 32'(timeout_err), 0);
    @(negedge clk);
    check("wd timeout_err pulse", 32'(timeout_err), 1);
    check("wd no grant in pulse", 32'(req_ready), 0);
    @(posedge clk);
    #1;
    stub_mode = M_NORMAL;
    @(negedge clk);
    check("wd next grant", 32'(req_ready), 1);
    check("wd timeout_err after", 32'(timeout_err), 0);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_fd("wd fd count", 9);

    // Coincident tx_done and watchdog limit: done wins.
    @(posedge clk);
    #1;
    stub_mode = M_LATE_DONE;
    req_valid = 3'b010;
    req_data  = {8'h00, 8'hD1, 8'h00};
    expect_frame(2'd1, 8'hD1);
    wait_ready("coinc grant", 2);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    check("coinc send_en", 32'(send_en), 1);
    repeat (START_TIMEOUT + 1) @(negedge clk);
    check("coinc timeout_err at limit", 32'(timeout_err), 0);
    @(negedge clk);
    check("coinc frame_done", 32'(frame_done), 1);
    check("coinc timeout_err after", 32'(timeout_err), 0);
    @(posedge clk);
    #1;
    stub_mode = M_NORMAL;
    wait_fd("coinc fd count", 10);

    // Reset during WAIT_DONE: outputs zero, then requester 0 first once idle.
    @(posedge clk);
    #1;
    req_valid = 3'b100;
    req_data  = {8'h5A, 8'h00, 8'h00};
    expect_frame(2'd2, 8'h5A);
    wait_ready("midrst grant", 4);
    @(posedge clk);
    #1;
    req_valid = '0;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 3'b111;
    req_data  = {8'hE2, 8'hE1, 8'hE0};
    @(negedge clk);
    check_reset_outputs("midrst held");
    repeat (2) @(negedge clk);
    check("midrst held req_ready late", 32'(req_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_frame(2'd0, 8'hE0);
    wait_ready("midrst first after reset", 1);
    check("midrst grant with busy low", 32'(tx_busy), 0);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_fd("midrst fd count", 11);

    // Bookkeeping across the whole run.
    repeat (5) @(negedge clk);
    check("scoreboard drained", sb_q.size(), 0);
    check("serial queue drained", ser_q.size(), 0);
    check("send_en total", send_cnt, 13);
    check("serial bytes total", rx_cnt, 11);
    check("timeout total", to_cnt, 1);
    check("frame_done total", fd_cnt, 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
